// File: rtl/fracture_pkg.sv
// rtl/fracture_pkg.sv - shared types and widths for the fracture detector
package fracture_pkg;

  localparam int NCH   = 8;
  localparam int CH_W  = 3;
  localparam int RC_W  = 8;
  localparam int WIN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } frac_state_t;

endpackage

// File: rtl/fracture_det_if.sv
// rtl/fracture_det_if.sv - time-multiplexed sample stream bundle
interface fracture_det_if;
  import fracture_pkg::*;

  logic                   smp_vld;
  logic [CH_W-1:0]        smp_ch;
  logic signed [15:0]     smp_data;

  modport master (output smp_vld, output smp_ch, output smp_data);
  modport slave  (input  smp_vld, input  smp_ch, input  smp_data);

endinterface

// File: rtl/fracture_mag.sv
// rtl/fracture_mag.sv - saturating magnitude and ring-threshold compare
module fracture_mag (
  input  logic signed [15:0] smp_data,
  input  logic [15:0]        cfg_ring_th,
  output logic               above
);

  logic [15:0] mag;

  // -32768 has no positive counterpart, so it clamps to 32767; any
  // threshold above 32767 can then never be reached.
  always_comb begin
    if (smp_data == 16'sh8000) begin
      mag = 16'h7FFF;
    end else if (smp_data[15]) begin
      mag = 16'(-smp_data);
    end else begin
      mag = smp_data;
    end
    above = (mag >= cfg_ring_th);
  end

endmodule

// File: rtl/fracture_det.sv
// rtl/fracture_det.sv - per-channel ring-count fracture detector with sticky status
module fracture_det
  import fracture_pkg::*;
#(
  parameter int RING_MIN = 4,
  parameter int WIN_LEN  = 1024
) (
  input  logic              clk_sys,
  input  logic              rst,
  fracture_det_if.slave     smp,
  input  logic [15:0]       cfg_ring_th,
  input  logic [NCH-1:0]    clr_fracture,
  output logic [NCH-1:0]    stu_fracture,
  output logic              frac_evt,
  output logic [CH_W-1:0]   frac_ch
);

  frac_state_t      st_q [NCH];
  logic [RC_W-1:0]  rc_q [NCH];
  logic [WIN_W-1:0] wc_q [NCH];
  logic [NCH-1:0]   prev_q;

  logic             above;
  logic             crossing;
  frac_state_t      cur_st, nxt_st;
  logic [RC_W-1:0]  cur_rc, nxt_rc, rc_inc;
  logic [WIN_W-1:0] cur_wc, nxt_wc, wc_inc;
  logic             declare;
  logic             decl_v;
  logic [NCH-1:0]   set_mask;

  fracture_mag u_mag (
    .smp_data    (smp.smp_data),
    .cfg_ring_th (cfg_ring_th),
    .above       (above)
  );

  // Only the addressed channel is read and rewritten each cycle, so a
  // back-to-back sample of the same channel sees the just-written state.
  always_comb begin
    cur_st   = st_q[smp.smp_ch];
    cur_rc   = rc_q[smp.smp_ch];
    cur_wc   = wc_q[smp.smp_ch];
    crossing = above & ~prev_q[smp.smp_ch];
    rc_inc   = (cur_rc == {RC_W{1'b1}}) ? cur_rc : cur_rc + 1'b1;
    wc_inc   = cur_wc + 1'b1;
    nxt_st   = cur_st;
    nxt_rc   = cur_rc;
    nxt_wc   = cur_wc;
    declare  = 1'b0;
    case (cur_st)
      ST_IDLE: begin
        if (crossing) begin
          nxt_rc = RC_W'(1);
          nxt_wc = '0;
          if (RING_MIN == 1) begin
            declare = 1'b1;
            nxt_st  = ST_HOLD;
          end else begin
            nxt_st  = ST_COUNT;
          end
        end
      end
      ST_COUNT: begin
        nxt_wc = wc_inc;
        if (crossing) nxt_rc = rc_inc;
        if (crossing && (rc_inc == RC_W'(RING_MIN))) begin
          declare = 1'b1;
          nxt_st  = ST_HOLD;
        end else if (wc_inc == WIN_W'(WIN_LEN - 1)) begin
          nxt_st = ST_IDLE;
          nxt_rc = '0;
        end
      end
      ST_HOLD: begin
        nxt_wc = wc_inc;
        if (wc_inc == WIN_W'(WIN_LEN - 1)) begin
          nxt_st = ST_IDLE;
          nxt_rc = '0;
        end
      end
      default: begin
        nxt_st = ST_IDLE;
        nxt_rc = '0;
        nxt_wc = '0;
      end
    endcase
    decl_v   = smp.smp_vld & declare;
    set_mask = decl_v ? ({{(NCH-1){1'b0}}, 1'b1} << smp.smp_ch) : '0;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        st_q[i] <= ST_IDLE;
        rc_q[i] <= '0;
        wc_q[i] <= '0;
      end
      prev_q       <= '0;
      stu_fracture <= '0;
      frac_evt     <= 1'b0;
      frac_ch      <= '0;
    end else begin
      // Set wins over a same-cycle clear of the same bit.
      stu_fracture <= (stu_fracture & ~clr_fracture) | set_mask;
      frac_evt     <= decl_v;
      if (decl_v) frac_ch <= smp.smp_ch;
      if (smp.smp_vld) begin
        st_q[smp.smp_ch]   <= nxt_st;
        rc_q[smp.smp_ch]   <= nxt_rc;
        wc_q[smp.smp_ch]   <= nxt_wc;
        prev_q[smp.smp_ch] <= above;
      end
    end
  end

endmodule

// File: tb/tb_fracture_det.sv
// tb/tb_fracture_det.sv - scoreboard bench for fracture_det
module tb_fracture_det;
  import fracture_pkg::*;

  localparam int WL = 1024;

  typedef struct {
    logic       evt;
    logic [2:0] ch;
    logic [7:0] stu;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cfg_ring_th = 16'd30;
  logic [7:0]  clr_fracture = 8'h00;
  logic [7:0]  stu_fracture;
  logic        frac_evt;
  logic [2:0]  frac_ch;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  fracture_det_if smp_if ();

  fracture_det #(.RING_MIN(4), .WIN_LEN(WL)) dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .smp          (smp_if),
    .cfg_ring_th  (cfg_ring_th),
    .clr_fracture (clr_fracture),
    .stu_fracture (stu_fracture),
    .frac_evt     (frac_evt),
    .frac_ch      (frac_ch)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step(input logic v, input logic [2:0] c, input logic [15:0] d, input logic [7:0] clr);
    smp_if.smp_vld  = v;
    smp_if.smp_ch   = c;
    smp_if.smp_data = d;
    clr_fracture    = clr;
    @(posedge clk_sys);
    #1;
    smp_if.smp_vld = 1'b0;
    clr_fracture   = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 3'd0, 16'd0, 8'h00);
    step(1'b0, 3'd0, 16'd0, 8'h00);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    smp_if.smp_vld = 1'b0;
    smp_if.smp_ch = 3'd0;
    smp_if.smp_data = 16'd0;
    do_reset();
    checks += 3;
    if (stu_fracture !== 8'h00) begin failures++; $display("FAIL reset_stu got=%h exp=00", stu_fracture); end
    if (frac_evt !== 1'b0) begin failures++; $display("FAIL reset_evt got=%b exp=0", frac_evt); end
    if (frac_ch !== 3'd0) begin failures++; $display("FAIL reset_ch got=%0d exp=0", frac_ch); end
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{evt: 1'b0, ch: 3'd0, stu: 8'h00});
      step(1'b0, 3'd0, 16'd0, 8'h00);
      e = sb.pop_front();
      checks += 2;
      if (frac_evt !== e.evt) begin failures++; $display("FAIL idle_evt i=%0d got=%b exp=%b", i, frac_evt, e.evt); end
      if (stu_fracture !== e.stu) begin failures++; $display("FAIL idle_stu i=%0d got=%h exp=%h", i, stu_fracture, e.stu); end
    end
  endtask

  task automatic test_ring();
    cfg_ring_th = 16'd30;
    for (int i = 0; i < 12; i++) begin
      sb.push_back('{evt: (i == 6), ch: 3'd2, stu: (i >= 6) ? 8'h04 : 8'h00});
      step(1'b1, 3'd2, (i % 2 == 0) ? 16'd40 : 16'd0, 8'h00);
      e = sb.pop_front();
      checks += 2;
      if (frac_evt !== e.evt) begin failures++; $display("FAIL ring_evt i=%0d got=%b exp=%b", i, frac_evt, e.evt); end
      if (stu_fracture !== e.stu) begin failures++; $display("FAIL ring_stu i=%0d got=%h exp=%h", i, stu_fracture, e.stu); end
      if (e.evt) begin
        checks++;
        if (frac_ch !== e.ch) begin failures++; $display("FAIL ring_ch got=%0d exp=%0d", frac_ch, e.ch); end
      end
    end
    checks++;
    if (frac_ch !== 3'd2) begin failures++; $display("FAIL ring_ch_held got=%0d exp=2", frac_ch); end
  endtask

  task automatic test_window();
    logic [15:0] d;
    do_reset();
    cfg_ring_th = 16'd30;
    // ch5: 3 rings, window closes exactly at sample WL-1, then 3 fresh rings
    for (int i = 0; i < WL + 5; i++) begin
      d = ((i < 5 || i >= WL) && (i % 2 == 0)) ? 16'd40 : 16'd0;
      sb.push_back('{evt: 1'b0, ch: 3'd0, stu: 8'h00});
      step(1'b1, 3'd5, d, 8'h00);
      e = sb.pop_front();
      checks += 2;
      if (frac_evt !== e.evt) begin failures++; $display("FAIL win_evt i=%0d got=%b exp=%b", i, frac_evt, e.evt); end
      if (stu_fracture !== e.stu) begin failures++; $display("FAIL win_stu i=%0d got=%h exp=%h", i, stu_fracture, e.stu); end
    end
    // ch4: 4th ring lands on the last window sample, declaration wins
    for (int i = 0; i < WL; i++) begin
      d = ((i < 5 && i % 2 == 0) || i == WL - 1) ? 16'd40 : 16'd0;
      sb.push_back('{evt: (i == WL - 1), ch: 3'd4, stu: (i == WL - 1) ? 8'h10 : 8'h00});
      step(1'b1, 3'd4, d, 8'h00);
      e = sb.pop_front();
      checks += 2;
      if (frac_evt !== e.evt) begin failures++; $display("FAIL edge_evt i=%0d got=%b exp=%b", i, frac_evt, e.evt); end
      if (stu_fracture !== e.stu) begin failures++; $display("FAIL edge_stu i=%0d got=%h exp=%h", i, stu_fracture, e.stu); end
    end
    checks++;
    if (frac_ch !== 3'd4) begin failures++; $display("FAIL edge_ch got=%0d exp=4", frac_ch); end
  endtask

  task automatic test_clear();
    do_reset();
    cfg_ring_th = 16'd30;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{evt: (i == 6), ch: 3'd0, stu: (i >= 6) ? 8'h01 : 8'h00});
      step(1'b1, 3'd0, (i % 2 == 0) ? 16'd40 : 16'd0, 8'h00);
      e = sb.pop_front();
      checks += 2;
      if (frac_evt !== e.evt) begin failures++; $display("FAIL clr_decl_evt i=%0d got=%b exp=%b", i, frac_evt, e.evt); end
      if (stu_fracture !== e.stu) begin failures++; $display("FAIL clr_decl_stu i=%0d got=%h exp=%h", i, stu_fracture, e.stu); end
    end
    sb.push_back('{evt: 1'b0, ch: 3'd0, stu: 8'h00});
    step(1'b0, 3'd0, 16'd0, 8'h01);
    e = sb.pop_front();
    checks++;
    if (stu_fracture !== e.stu) begin failures++; $display("FAIL clr_only got=%h exp=%h", stu_fracture, e.stu); end
    // finish ch0's hold window: samples 8..WL-1 of that window
    for (int i = 8; i < WL; i++) step(1'b1, 3'd0, 16'd0, 8'h00);
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{evt: (i == 6), ch: 3'd0, stu: (i == 6) ? 8'h01 : 8'h00});
      step(1'b1, 3'd0, (i % 2 == 0) ? 16'd40 : 16'd0, (i == 6) ? 8'h01 : 8'h00);
      e = sb.pop_front();
      checks += 2;
      if (frac_evt !== e.evt) begin failures++; $display("FAIL setwin_evt i=%0d got=%b exp=%b", i, frac_evt, e.evt); end
      if (stu_fracture !== e.stu) begin failures++; $display("FAIL setwin_stu i=%0d got=%h exp=%h", i, stu_fracture, e.stu); end
    end
  endtask

  task automatic test_mag();
    do_reset();
    cfg_ring_th = 16'd32767;
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{evt: (i == 6), ch: 3'd4, stu: (i == 6) ? 8'h10 : 8'h00});
      step(1'b1, 3'd4, (i % 2 == 0) ? 16'h8000 : 16'd0, 8'h00);
      e = sb.pop_front();
      checks += 2;
      if (frac_evt !== e.evt) begin failures++; $display("FAIL sat_evt i=%0d got=%b exp=%b", i, frac_evt, e.evt); end
      if (stu_fracture !== e.stu) begin failures++; $display("FAIL sat_stu i=%0d got=%h exp=%h", i, stu_fracture, e.stu); end
    end
    cfg_ring_th = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{evt: 1'b0, ch: 3'd7, stu: 8'h10});
      step(1'b1, 3'd7, (i % 2 == 0) ? 16'h8000 : 16'h7FFF, 8'h00);
      if (i % 2 == 1) step(1'b1, 3'd7, 16'd0, 8'h00);
      e = sb.pop_front();
      checks += 2;
      if (frac_evt !== e.evt) begin failures++; $display("FAIL maxth_evt i=%0d got=%b exp=%b", i, frac_evt, e.evt); end
      if (stu_fracture !== e.stu) begin failures++; $display("FAIL maxth_stu i=%0d got=%h exp=%h", i, stu_fracture, e.stu); end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  c;
    logic [15:0] d;
    logic [7:0]  s;
    do_reset();
    cfg_ring_th = 16'd30;
    s = 8'h00;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        c = (j % 2 == 0) ? 3'd1 : 3'd6;
        d = (j < 2) ? 16'd40 : 16'd0;
        if (k == 3 && j == 0) s = 8'h02;
        if (k == 3 && j == 1) s = 8'h42;
        sb.push_back('{evt: (k == 3 && j < 2), ch: c, stu: s});
        step(1'b1, c, d, 8'h00);
        e = sb.pop_front();
        checks += 2;
        if (frac_evt !== e.evt) begin failures++; $display("FAIL b2b_evt k=%0d j=%0d got=%b exp=%b", k, j, frac_evt, e.evt); end
        if (stu_fracture !== e.stu) begin failures++; $display("FAIL b2b_stu k=%0d j=%0d got=%h exp=%h", k, j, stu_fracture, e.stu); end
        if (e.evt) begin
          checks++;
          if (frac_ch !== e.ch) begin failures++; $display("FAIL b2b_ch got=%0d exp=%0d", frac_ch, e.ch); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    cfg_ring_th = 16'd30;
    for (int i = 0; i < 5; i++) step(1'b1, 3'd3, (i % 2 == 0) ? 16'd40 : 16'd0, 8'h00);
    step(1'b1, 3'd3, 16'd0, 8'h00);
    rst = 1'b1;
    step(1'b1, 3'd3, 16'd40, 8'h00);
    rst = 1'b0;
    checks += 3;
    if (stu_fracture !== 8'h00) begin failures++; $display("FAIL rmid_stu got=%h exp=00", stu_fracture); end
    if (frac_evt !== 1'b0) begin failures++; $display("FAIL rmid_evt got=%b exp=0", frac_evt); end
    if (frac_ch !== 3'd0) begin failures++; $display("FAIL rmid_ch got=%0d exp=0", frac_ch); end
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{evt: 1'b0, ch: 3'd0, stu: 8'h00});
      step(1'b1, 3'd3, (i % 2 == 1) ? 16'd40 : 16'd0, 8'h00);
      e = sb.pop_front();
      checks += 2;
      if (frac_evt !== e.evt) begin failures++; $display("FAIL rmid_post_evt i=%0d got=%b exp=%b", i, frac_evt, e.evt); end
      if (stu_fracture !== e.stu) begin failures++; $display("FAIL rmid_post_stu i=%0d got=%h exp=%h", i, stu_fracture, e.stu); end
    end
  endtask

  initial begin
    test_reset();
    test_ring();
    test_back_to_back();
    test_reset_mid();
    test_window();
    test_clear();
    test_mag();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
